regfile_writeback_queue: RTL and testbench
==========================================

# regfile_writeback_queue

Write-side feeder for the 4x16 two-write-port register file. It accepts writeback results from two producer lanes through a valid/ready handshake and buffers them in program order in a small FIFO. It drains the FIFO onto the register file's `wr1`/`wr2` ports, issuing up to two writes per cycle and never two writes to the same register in one cycle. It also exports a per-register pending mask so the operand-read stage can detect in-flight writes.

## Interface
- `DATA_WIDTH`, 16, register data width
- `ADDR_WIDTH`, 2, register index width; register count is 2**ADDR_WIDTH
- `DEPTH`, 4, FIFO entries; power of two, at least 2
- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset; asserting it (low) clears all state immediately
- `in1_valid`  in  1  lane 1 result valid; lane 1 is older than lane 2
- `in1_addr`  in  ADDR_WIDTH  lane 1 destination register
- `in1_data`  in  DATA_WIDTH  lane 1 result
- `in2_valid`  in  1  lane 2 result valid
- `in2_addr`  in  ADDR_WIDTH  lane 2 destination register
- `in2_data`  in  DATA_WIDTH  lane 2 result
- `in_ready`  out  1  both lanes may push this cycle
- `wr1`  out  ADDR_WIDTH  register file write port 1 address
- `wr1_data`  out  DATA_WIDTH  write port 1 data
- `wr1_enable`  out  1  write port 1 enable
- `wr2`  out  ADDR_WIDTH  write port 2 address
- `wr2_data`  out  DATA_WIDTH  write port 2 data
- `wr2_enable`  out  1  write port 2 enable
- `pending`  out  2**ADDR_WIDTH  bit r set while any un-retired write targets register r
- `count`  out  clog2(DEPTH+1)  current FIFO occupancy

## Operation
- FIFO: circular buffer of {addr, data}; read and write pointers wrap modulo DEPTH; occupancy tracked in `count`.
- Push:
  - `in_ready` = (DEPTH - `count`) >= 2. It is combinational from registered `count` only, with no dependence on same-cycle pops.
  - A lane is accepted when its valid is high and `in_ready` is high.
  - If both lanes are accepted, lane 1 is written at the tail and lane 2 at tail+1.
  - If only lane 2 is valid, it is written alone at the tail.
  - Valids while `in_ready` is low are ignored. Producers hold their data.
- Pop (every edge, from entries present before the edge):
  - `count` = 0: no pop; `wr1_enable` and `wr2_enable` go to 0.
  - `count` = 1, or head and head+1 have the same addr: pop 1. Head goes to `wr1`/`wr1_data` with `wr1_enable`=1; `wr2_enable`=0.
  - `count` >= 2 and the addresses differ: pop 2. Head goes to port 1 and head+1 to port 2; both enables are 1.
- Write ports are registered. The register file commits them on the following edge.
- Simultaneous push and pop in one cycle: `count` next = `count` + pushed - popped. Overflow is impossible by construction of `in_ready`.
- `pending[r]` is the OR of:
  - any valid FIFO entry with addr r
  - `wr1_enable` && `wr1`==r
  - `wr2_enable` && `wr2`==r
  
  It is combinational from registered state.
- Same-register writes are always retired in acceptance order. Two writes to one register never appear on `wr1`/`wr2` in the same cycle.

## Timing
- Reset (`reset` low, asynchronously):
  - `count`=0, pointers=0
  - `wr1`=0, `wr1_data`=0, `wr1_enable`=0
  - `wr2`=0, `wr2_data`=0, `wr2_enable`=0
  - `pending`=0, `in_ready`=1
  - Inputs have no effect while reset is low.
- Reset asserted mid-operation discards all buffered and presented writes. Enables drop immediately, without waiting for a clock edge.
- Latency:
  - A result accepted at edge N into an empty FIFO appears on the write port after edge N+1.
  - The register file holds the value after edge N+2.
  - `pending` rises after edge N and falls after edge N+2, provided no other write to that register is in flight.
- Throughput: 2 writes per cycle sustained when consecutive entries target distinct registers. It drops to 1 per cycle on same-register pairs.
- Full: `count`=DEPTH-1 or DEPTH drives `in_ready` low. It returns high in the cycle after a pop brings `count` to DEPTH-2 or below.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble. A two-entry pop may span the wrap (entries DEPTH-1 and 0).

## Test plan
- Reset check: hold `reset` low, then release.
  - All outputs are 0, `in_ready`=1, `count`=0.
  - Pulse `reset` low between edges while `wr1_enable`=1: the enable drops immediately.
- Dual push, distinct registers: in1={1,0x0010} and in2={3,0x0020} at edge N.
  - After N+1: `wr1`=1/0x0010 and `wr2`=3/0x0020, both enables 1.
  - `pending`=4'b1010 from N through N+2, then 0.
- Same-register pair: in1={2,0xABCD} and in2={2,0x1234}.
  - Port 1 writes 0xABCD alone in one cycle, then 0x1234 on port 1 in the next cycle.
  - `wr2_enable` stays 0 for both cycles.
  - The register file ends holding 0x1234.
- Fill to full: push two per cycle for 2 cycles with a stalled drain (same-addr stream to register 0).
  - `count` reaches 3 or 4 and `in_ready` falls.
  - Valids held during the stall are not accepted; no entry is lost or duplicated.
- Wrap-around: push 10 results alternating registers 0..3 with data 0x0100+i, with random valid gaps.
  - Write order on the ports matches push order.
  - Every pair issued in one cycle has distinct addresses.
- Lane-2-only push: in2={3,0xBEEF} with `in1_valid`=0.
  - `wr1`=3/0xBEEF after the next edge; `wr2_enable`=0.

Source files
------------

// File: rtl/regfile_writeback_queue.sv
// Purpose: buffers two-lane writeback results in order and drains them onto the wr1/wr2 register file ports.
// Latency: a result accepted into an empty queue is on the write port one edge later; the register file holds it one edge after that.
// Backpressure: in_ready is low whenever fewer than two slots are free; lanes are then ignored and producers hold their data.
module regfile_writeback_queue #(
    parameter int  DATA_WIDTH = 16,
    parameter int  ADDR_WIDTH = 2,
    parameter int  DEPTH      = 4,
    localparam int REGS       = 2**ADDR_WIDTH,
    localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in1_valid,
    input  logic [ADDR_WIDTH-1:0] in1_addr,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic                  in2_valid,
    input  logic [ADDR_WIDTH-1:0] in2_addr,
    input  logic [DATA_WIDTH-1:0] in2_data,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] wr1,
    output logic [DATA_WIDTH-1:0] wr1_data,
    output logic                  wr1_enable,
    output logic [ADDR_WIDTH-1:0] wr2,
    output logic [DATA_WIDTH-1:0] wr2_data,
    output logic                  wr2_enable,
    output logic [REGS-1:0]       pending,
    output logic [CNT_W-1:0]      count
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] dat;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;
    logic             push_1;
    logic             push_2;
    logic [1:0]       n_push;
    logic             pair_conflict;
    logic             pop_one;
    logic             pop_two;
    logic [1:0]       n_pop;
    entry_t           in1_entry;
    entry_t           in2_entry;

    assign head_p1   = head + PTR_W'(1);
    assign tail_p1   = tail + PTR_W'(1);
    assign in1_entry = '{addr: in1_addr, dat: in1_data};
    assign in2_entry = '{addr: in2_addr, dat: in2_data};

    // Readiness looks only at registered occupancy, so it never depends on this cycle's drain.
    assign in_ready = (count <= CNT_W'(DEPTH - 2));
    assign push_1   = in1_valid & in_ready;
    assign push_2   = in2_valid & in_ready;
    assign n_push   = {1'b0, push_1} + {1'b0, push_2};

    // A same-register pair would race inside the register file, so it drains one at a time.
    assign pair_conflict = (mem[head].addr == mem[head_p1].addr);
    assign pop_two       = (count >= CNT_W'(2)) && !pair_conflict;
    assign pop_one       = (count != '0) && !pop_two;
    assign n_pop         = pop_two ? 2'd2 : (pop_one ? 2'd1 : 2'd0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            wr1        <= '0;
            wr1_data   <= '0;
            wr1_enable <= 1'b0;
            wr2        <= '0;
            wr2_data   <= '0;
            wr2_enable <= 1'b0;
        end else begin
            if (push_1) begin
                mem[tail] <= in1_entry;
            end
            if (push_2) begin
                mem[push_1 ? tail_p1 : tail] <= in2_entry;
            end
            tail  <= tail + PTR_W'(n_push);
            head  <= head + PTR_W'(n_pop);
            count <= count + CNT_W'(n_push) - CNT_W'(n_pop);

            wr1_enable <= pop_one | pop_two;
            wr2_enable <= pop_two;
            if (pop_one | pop_two) begin
                wr1      <= mem[head].addr;
                wr1_data <= mem[head].dat;
            end
            if (pop_two) begin
                wr2      <= mem[head_p1].addr;
                wr2_data <= mem[head_p1].dat;
            end
        end
    end

    // In-flight means still queued or sitting on a write port awaiting commit.
    always_comb begin
        pending = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < count) begin
                pending[mem[head + PTR_W'(k)].addr] = 1'b1;
            end
        end
        if (wr1_enable) begin
            pending[wr1] = 1'b1;
        end
        if (wr2_enable) begin
            pending[wr2] = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: queue-level reference model compared every cycle, plus literal spot checks.
module tb_regfile_writeback_queue;

    localparam int DW    = 16;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          in1_valid, in2_valid;
    logic [AW-1:0] in1_addr, in2_addr;
    logic [DW-1:0] in1_data, in2_data;
    logic          in_ready;
    logic [AW-1:0] wr1, wr2;
    logic [DW-1:0] wr1_data, wr2_data;
    logic          wr1_enable, wr2_enable;
    logic [3:0]    pending;
    logic [2:0]    count;

    int tests = 0;
    int fails = 0;

    regfile_writeback_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .in1_valid(in1_valid), .in1_addr(in1_addr), .in1_data(in1_data),
        .in2_valid(in2_valid), .in2_addr(in2_addr), .in2_data(in2_data),
        .in_ready(in_ready),
        .wr1(wr1), .wr1_data(wr1_data), .wr1_enable(wr1_enable),
        .wr2(wr2), .wr2_data(wr2_data), .wr2_enable(wr2_enable),
        .pending(pending), .count(count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of accepted writes plus the two write-port slots.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    logic          m1_en = 1'b0, m2_en = 1'b0;
    logic [AW-1:0] m1_a = '0, m2_a = '0;
    logic [DW-1:0] m1_d = '0, m2_d = '0;
    logic [DW-1:0] mrf [4];
    logic [DW-1:0] rf  [4];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m1_en = 1'b0;
            m2_en = 1'b0;
        end else begin
            int  n;
            bit  rdy;
            n   = mq.size();
            rdy = (DEPTH - n) >= 2;
            if (m1_en) mrf[m1_a] = m1_d;
            if (m2_en) mrf[m2_a] = m2_d;
            m1_en = 1'b0;
            m2_en = 1'b0;
            if (n >= 2 && mq[0].a != mq[1].a) begin
                m1_a = mq[0].a; m1_d = mq[0].d; m1_en = 1'b1;
                m2_a = mq[1].a; m2_d = mq[1].d; m2_en = 1'b1;
                void'(mq.pop_front());
                void'(mq.pop_front());
            end else if (n >= 1) begin
                m1_a = mq[0].a; m1_d = mq[0].d; m1_en = 1'b1;
                void'(mq.pop_front());
            end
            if (rdy && in1_valid) mq.push_back('{a: in1_addr, d: in1_data});
            if (rdy && in2_valid) mq.push_back('{a: in2_addr, d: in2_data});
        end
    end

    function automatic logic [3:0] model_pending();
        logic [3:0] p;
        p = '0;
        foreach (mq[i]) p[mq[i].a] = 1'b1;
        if (m1_en) p[m1_a] = 1'b1;
        if (m2_en) p[m2_a] = 1'b1;
        return p;
    endfunction

    always @(posedge clock) begin
        if (wr1_enable) rf[wr1] <= wr1_data;
        if (wr2_enable) rf[wr2] <= wr2_data;
    end

    always @(negedge clock) begin
        chk("count", 32'(count), 32'(mq.size()));
        chk("in_ready", 32'(in_ready), 32'((DEPTH - mq.size()) >= 2));
        chk("wr1_enable", 32'(wr1_enable), 32'(m1_en));
        chk("wr2_enable", 32'(wr2_enable), 32'(m2_en));
        chk("pending", 32'(pending), 32'(model_pending()));
        if (m1_en) begin
            chk("wr1", 32'(wr1), 32'(m1_a));
            chk("wr1_data", 32'(wr1_data), 32'(m1_d));
        end
        if (m2_en) begin
            chk("wr2", 32'(wr2), 32'(m2_a));
            chk("wr2_data", 32'(wr2_data), 32'(m2_d));
        end
        if (wr1_enable && wr2_enable) chk("pair_distinct", 32'(wr1 == wr2), 32'd0);
    end

    // Call at a negedge; holds the vectors until accepted, returns at the negedge after acceptance.
    task automatic push(input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic v2, input logic [AW-1:0] a2, input logic [DW-1:0] d2);
        int t;
        in1_valid = v1; in1_addr = a1; in1_data = d1;
        in2_valid = v2; in2_addr = a2; in2_data = d2;
        t = 0;
        while (!in_ready && t < 64) begin
            @(negedge clock);
            t++;
        end
        if (t >= 64) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: in_ready stuck low, required high within 64 cycles");
        end
        @(negedge clock);
        in1_valid = 1'b0;
        in2_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int i, r;
        reset = 1'b0;
        in1_valid = 1'b0; in1_addr = '0; in1_data = '0;
        in2_valid = 1'b0; in2_addr = '0; in2_data = '0;
        idle(2);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_wr1", 32'({wr1, wr1_data, wr1_enable}), 32'd0);
        chk("rst_wr2", 32'({wr2, wr2_data, wr2_enable}), 32'd0);
        reset = 1'b1;
        idle(1);

        // Dual push to distinct registers.
        push(1'b1, 2'd1, 16'h0010, 1'b1, 2'd3, 16'h0020);
        chk("dual_pending_n", 32'(pending), 32'b1010);
        idle(1);
        chk("dual_wr1", 32'({wr1_enable, wr1, wr1_data}), {13'd0, 1'b1, 2'd1, 16'h0010});
        chk("dual_wr2", 32'({wr2_enable, wr2, wr2_data}), {13'd0, 1'b1, 2'd3, 16'h0020});
        chk("dual_pending_n1", 32'(pending), 32'b1010);
        idle(1);
        chk("dual_pending_n2", 32'(pending), 32'd0);
        idle(1);

        // Same-register pair drains one per cycle in order.
        push(1'b1, 2'd2, 16'hABCD, 1'b1, 2'd2, 16'h1234);
        idle(1);
        chk("same_first", 32'({wr1_enable, wr2_enable, wr1_data}), {14'd0, 2'b10, 16'hABCD});
        idle(1);
        chk("same_second", 32'({wr1_enable, wr2_enable, wr1_data}), {14'd0, 2'b10, 16'h1234});
        idle(1);
        chk("same_regfile", 32'(rf[2]), 32'h1234);

        // Fill with a stalled same-register stream.
        push(1'b1, 2'd0, 16'h00A0, 1'b1, 2'd0, 16'h00A1);
        push(1'b1, 2'd0, 16'h00A2, 1'b1, 2'd0, 16'h00A3);
        chk("full_count", 32'(count), 32'd3);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        push(1'b1, 2'd0, 16'h00A4, 1'b1, 2'd0, 16'h00A5);
        idle(8);
        chk("full_regfile", 32'(rf[0]), 32'h00A5);

        // Wrap-around with random gaps and lane mixes.
        i = 0;
        while (i < 10) begin
            r = $urandom_range(0, 3);
            if (r == 0) idle(1);
            else if (r == 1) begin
                push(1'b1, 2'(i % 4), 16'h0100 + 16'(i), 1'b0, 2'd0, 16'd0);
                i++;
            end else if (r == 2 || i == 9) begin
                push(1'b0, 2'd0, 16'd0, 1'b1, 2'(i % 4), 16'h0100 + 16'(i));
                i++;
            end else begin
                push(1'b1, 2'(i % 4), 16'h0100 + 16'(i), 1'b1, 2'((i + 1) % 4), 16'h0101 + 16'(i));
                i += 2;
            end
        end
        idle(6);
        chk("wrap_rf3", 32'(rf[3]), 32'h0107);
        chk("wrap_rf1", 32'(rf[1]), 32'h0109);

        // Lane 2 alone lands at the tail and drains on port 1.
        push(1'b0, 2'd0, 16'd0, 1'b1, 2'd3, 16'hBEEF);
        idle(1);
        chk("lane2_wr1", 32'({wr1_enable, wr2_enable, wr1, wr1_data}), {12'd0, 2'b10, 2'd3, 16'hBEEF});
        idle(2);

        // Asynchronous reset between edges drops the enable immediately.
        push(1'b1, 2'd1, 16'h0055, 1'b0, 2'd0, 16'd0);
        idle(1);
        chk("pulse_before", 32'(wr1_enable), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("pulse_enable", 32'(wr1_enable), 32'd0);
        chk("pulse_pending", 32'(pending), 32'd0);
        #1 reset = 1'b1;
        idle(3);

        for (int k = 0; k < 4; k++) chk("regfile_final", 32'(rf[k]), 32'(mrf[k]));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
